dpram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly in front of, and behind, the 64 x 8 dual-port synchronous RAM.
- It drives port A as the write port and port B as the read port, and consumes the RAM's registered port-B output.
- It converts a valid/ready producer stream into RAM writes, and RAM reads into a valid/ready consumer stream.
- Storage stays in the RAM; this block owns only pointers, occupancy and handshakes.

---
 rtl/dpram_fifo_ctrl.sv | 75 +++++++
 tb/tb_dpram_fifo_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller wrapped around a 64 x 8 dual-port synchronous RAM.
// Port A writes at the tail, port B continuously reads the head; this block owns pointers and handshakes.
module dpram_fifo_ctrl #(
    parameter int DW       = 8,
    parameter int AW       = 6,
    parameter int AF_LEVEL = 56
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW-1:0] ram_addr_A,
    output logic [DW-1:0] ram_data_in_A,
    output logic          ram_mode_A,
    output logic [AW-1:0] ram_addr_B,
    output logic          ram_mode_B,
    input  logic [DW-1:0] ram_data_out_B
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign wr_ready = rst_n & (count < DEPTH_C);
    assign push     = wr_valid & wr_ready & ~flush;
    assign pop      = rd_valid & rd_ready & ~flush;

    assign ram_addr_A    = wr_ptr;
    assign ram_data_in_A = wr_data;
    assign ram_mode_A    = push;

    // Fetch the next head on the same edge as a pop so back-to-back pops have no bubble.
    assign ram_addr_B = rd_ptr + AW'(pop);
    assign ram_mode_B = 1'b0;
    assign rd_data    = ram_data_out_B;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);

    // A push into an empty FIFO is not counted for rd_valid: the RAM returns the old word on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            rd_valid <= ((count - (AW+1)'(pop)) != '0);
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural 64 x 8 dual-port RAM and a data scoreboard.
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [6:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [5:0] ram_addr_A;
    logic [7:0] ram_data_in_A;
    logic       ram_mode_A;
    logic [5:0] ram_addr_B;
    logic       ram_mode_B;
    logic [7:0] ram_data_out_B = 8'h00;

    logic [7:0] mem [64];
    logic [7:0] sb [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         pops = 0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DW(8), .AW(6), .AF_LEVEL(56)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .ram_addr_A(ram_addr_A), .ram_data_in_A(ram_data_in_A), .ram_mode_A(ram_mode_A),
        .ram_addr_B(ram_addr_B), .ram_mode_B(ram_mode_B), .ram_data_out_B(ram_data_out_B)
    );

    // Read-before-write RAM with a registered port B output.
    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_mode_A) mem[ram_addr_A] <= ram_data_in_A;
        if (!ram_mode_B) ram_data_out_B <= mem[ram_addr_B];
    end

    // Scoreboard: record accepted writes, compare every accepted read against the oldest.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (rd_valid && rd_ready) begin
                vectors++;
                pops++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL sb_underflow: pop of %02h with nothing expected", rd_data);
                end else begin
                    exp = sb.pop_front();
                    if (rd_data !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL sb_data: got %02h expected %02h", rd_data, exp);
                    end
                end
            end
            if (wr_valid && wr_ready) sb.push_back(wr_data);
        end
    end

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic fail(input string name, input int got, input int exp);
        miscompares++;
        $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
        #2 rst_n = 1'b0;
        wr_valid = 1'b1;
        @(negedge clk);
        vectors++; if (count !== 7'd0)     fail("reset_count", count, 0);
        vectors++; if (empty !== 1'b1)     fail("reset_empty", empty, 1);
        vectors++; if (full !== 1'b0)      fail("reset_full", full, 0);
        vectors++; if (almost_full !== 1'b0) fail("reset_af", almost_full, 0);
        vectors++; if (rd_valid !== 1'b0)  fail("reset_rd_valid", rd_valid, 0);
        vectors++; if (wr_ready !== 1'b0)  fail("reset_wr_ready", wr_ready, 0);
        vectors++; if (ram_mode_A !== 1'b0) fail("reset_mode_A", ram_mode_A, 0);
        vectors++; if (ram_mode_B !== 1'b0) fail("mode_B", ram_mode_B, 0);
        next_drive();
        rst_n = 1'b1; wr_valid = 1'b0;
        @(negedge clk);
        vectors++; if (wr_ready !== 1'b1)  fail("release_wr_ready", wr_ready, 1);
    endtask

    task automatic test_single_write();
        next_drive();
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        vectors++; if (ram_mode_A !== 1'b1)    fail("sw_mode_A", ram_mode_A, 1);
        vectors++; if (ram_addr_A !== 6'd0)    fail("sw_addr_A", ram_addr_A, 0);
        vectors++; if (ram_data_in_A !== 8'hA5) fail("sw_data_A", ram_data_in_A, 8'hA5);
        next_drive();
        wr_valid = 1'b0;
        @(negedge clk);
        vectors++; if (count !== 7'd1)      fail("sw_count", count, 1);
        vectors++; if (rd_valid !== 1'b0)   fail("sw_rd_valid_early", rd_valid, 0);
        vectors++; if (ram_mode_A !== 1'b0) fail("sw_mode_A_drop", ram_mode_A, 0);
        next_drive();
        rd_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b1) fail("sw_rd_valid", rd_valid, 1);
        vectors++; if (rd_data !== 8'hA5) fail("sw_rd_data", rd_data, 8'hA5);
        next_drive();
        rd_ready = 1'b0;
        @(negedge clk);
        vectors++; if (empty !== 1'b1 || rd_valid !== 1'b0) fail("sw_empty_after", {empty, rd_valid}, 2);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) begin
            next_drive();
            wr_valid = 1'b1; wr_data = 8'(i);
            @(negedge clk);
            vectors++; if (count !== 7'(i)) fail("fill_count", count, i);
            vectors++; if (wr_ready !== 1'b1) fail("fill_wr_ready", wr_ready, 1);
            vectors++; if (almost_full !== (i >= 56)) fail("fill_af", almost_full, int'(i >= 56));
        end
        next_drive();
        wr_valid = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        vectors++; if (count !== 7'd64)      fail("full_count", count, 64);
        vectors++; if (full !== 1'b1)        fail("full_flag", full, 1);
        vectors++; if (wr_ready !== 1'b0)    fail("full_wr_ready", wr_ready, 0);
        vectors++; if (ram_mode_A !== 1'b0)  fail("full_mode_A", ram_mode_A, 0);
        vectors++; if (almost_full !== 1'b1) fail("full_af", almost_full, 1);
        next_drive();
        wr_valid = 1'b0;
        @(negedge clk);
        vectors++; if (count !== 7'd64) fail("full_hold_count", count, 64);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 64; i++) begin
            next_drive();
            rd_ready = 1'b1;
            @(negedge clk);
            vectors++; if (rd_valid !== 1'b1) fail("drain_bubble", rd_valid, 1);
        end
        next_drive();
        rd_ready = 1'b0;
        @(negedge clk);
        vectors++; if (empty !== 1'b1)    fail("drain_empty", empty, 1);
        vectors++; if (rd_valid !== 1'b0) fail("drain_rd_valid", rd_valid, 0);
    endtask

    task automatic test_back_to_back();
        int start_pops;
        bit done;
        start_pops = pops;
        for (int i = 0; i < 200; i++) begin
            next_drive();
            wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'(i * 7 + 3);
            @(negedge clk);
            vectors++; if (count > 7'd2) fail("b2b_count", count, 2);
        end
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            next_drive();
            wr_valid = 1'b0;
            @(negedge clk);
            if (empty && !rd_valid) done = 1'b1;
        end
        vectors++; if (!done) fail("b2b_drain_timeout", count, 0);
        vectors++; if (pops - start_pops != 200) fail("b2b_pop_total", pops - start_pops, 200);
        rd_ready = 1'b0;
    endtask

    task automatic test_push_pop_at_one();
        next_drive();
        wr_valid = 1'b1; wr_data = 8'h5A;
        next_drive();
        wr_valid = 1'b0;
        next_drive();
        wr_valid = 1'b1; wr_data = 8'hC3; rd_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) fail("pp1_head", rd_data, 8'h5A);
        next_drive();
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b0) fail("pp1_gap", rd_valid, 0);
        vectors++; if (count !== 7'd1)    fail("pp1_count", count, 1);
        next_drive();
        rd_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b1) fail("pp1_return", rd_valid, 1);
        vectors++; if (rd_data !== 8'hC3) fail("pp1_data", rd_data, 8'hC3);
        next_drive();
        rd_ready = 1'b0;
        @(negedge clk);
        vectors++; if (empty !== 1'b1) fail("pp1_empty", empty, 1);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) begin
            next_drive();
            wr_valid = 1'b1; wr_data = 8'(8'h80 + i);
        end
        next_drive();
        wr_valid = 1'b1; wr_data = 8'hEE; flush = 1'b1;
        @(negedge clk);
        vectors++; if (count !== 7'd10)     fail("flush_pre_count", count, 10);
        vectors++; if (ram_mode_A !== 1'b0) fail("flush_mode_A", ram_mode_A, 0);
        next_drive();
        flush = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        vectors++; if (count !== 7'd0)     fail("flush_count", count, 0);
        vectors++; if (rd_valid !== 1'b0)  fail("flush_rd_valid", rd_valid, 0);
        next_drive();
        wr_valid = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        vectors++; if (ram_addr_A !== 6'd0 || ram_mode_A !== 1'b1) fail("flush_next_addr", ram_addr_A, 0);
        next_drive();
        wr_valid = 1'b0;
        next_drive();
        rd_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h77) fail("flush_next_data", rd_data, 8'h77);
        next_drive();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 6; i++) begin
            next_drive();
            wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (count !== 7'd0)    fail("arst_count", count, 0);
        vectors++; if (rd_valid !== 1'b0) fail("arst_rd_valid", rd_valid, 0);
        vectors++; if (wr_ready !== 1'b0) fail("arst_wr_ready", wr_ready, 0);
        next_drive();
        @(negedge clk);
        vectors++; if (wr_ready !== 1'b0 || ram_mode_A !== 1'b0) fail("arst_hold", wr_ready, 0);
        next_drive();
        rst_n = 1'b1; wr_valid = 1'b0;
        @(negedge clk);
        vectors++; if (wr_ready !== 1'b1) fail("arst_release", wr_ready, 1);
        next_drive();
        wr_valid = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        vectors++; if (ram_addr_A !== 6'd0) fail("arst_addr", ram_addr_A, 0);
        next_drive();
        wr_valid = 1'b0;
        next_drive();
        rd_ready = 1'b1;
        @(negedge clk);
        vectors++; if (rd_data !== 8'h3C) fail("arst_data", rd_data, 8'h3C);
        next_drive();
        rd_ready = 1'b0;
        @(negedge clk);
        vectors++; if (sb.size() != 0) fail("sb_leftover", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_drain();
        test_back_to_back();
        test_push_pop_at_one();
        test_flush();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
